// File: rtl/usb_bitstuff_enc.sv
// USB transmit bit-stuffing encoder: inserts a 0 after every RUN_LEN consecutive ones past the PID window.
// Latency: one cycle from input acceptance to out_valid; one input bubble per stuffed bit.
// Backpressure: out_ready low stalls the output register and drops in_ready in the same cycle.
//
// Ports:
//   clock, reset_n              single clock, synchronous active-low reset
//   in_valid/in_ready           upstream handshake; in_bit data, in_last marks final packet bit
//   out_valid/out_ready         downstream handshake; out_bit data, out_last marks final output bit
//   busy                        packet in flight (first acceptance until out_last handed off)
//   stuff_cnt                   stuffed bits in current/most recent packet, saturating
module usb_bitstuff_enc #(
    parameter int RUN_LEN   = 6,
    parameter int SKIP_BITS = 8,
    parameter int CNT_W     = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    input  logic             in_bit,
    input  logic             in_last,
    output logic             in_ready,
    output logic             out_valid,
    output logic             out_bit,
    output logic             out_last,
    input  logic             out_ready,
    output logic             busy,
    output logic [CNT_W-1:0] stuff_cnt
);

    typedef enum logic [1:0] {IDLE, SKIP, COUNT, STUFF} state_t;

    localparam logic       HAS_SKIP  = (SKIP_BITS > 0);
    localparam logic [7:0] SKIP_LAST = (SKIP_BITS > 0) ? 8'(SKIP_BITS - 1) : 8'd0;
    localparam logic [3:0] RUN_TGT   = 4'(RUN_LEN);

    state_t     state;
    logic [3:0] run;
    logic [7:0] skip_idx;
    logic       pend_last;

    logic       slot_free;
    logic       accept;
    logic       in_skip;
    logic [3:0] cur_run;
    logic [7:0] cur_skip;

    // In IDLE the first bit of a packet is processed as if run and skip_idx
    // were already cleared, so the packet-start clear and the first bit's
    // update happen in the same cycle.
    always_comb begin
        slot_free = ~out_valid | out_ready;
        in_ready  = slot_free & (state != STUFF);
        accept    = in_valid & in_ready;
        cur_run   = (state == IDLE) ? 4'd0 : run;
        cur_skip  = (state == IDLE) ? 8'd0 : skip_idx;
        in_skip   = (state == IDLE) ? HAS_SKIP : (state == SKIP);
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state     <= IDLE;
            run       <= 4'd0;
            skip_idx  <= 8'd0;
            pend_last <= 1'b0;
            out_valid <= 1'b0;
            out_bit   <= 1'b0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            stuff_cnt <= '0;
        end else begin
            // Handoff of the final beat ends the packet; a new first bit
            // accepted in the same cycle re-asserts busy below.
            if (out_valid && out_ready && out_last) begin
                busy <= 1'b0;
            end
            if (out_ready) begin
                out_valid <= 1'b0;
            end

            if (accept) begin
                out_valid <= 1'b1;
                out_bit   <= in_bit;
                out_last  <= in_last;
                if (state == IDLE) begin
                    stuff_cnt <= '0;
                    busy      <= 1'b1;
                end
                if (in_skip) begin
                    run      <= 4'd0;
                    skip_idx <= cur_skip + 8'd1;
                    if (in_last) begin
                        state <= IDLE;
                    end else if (cur_skip == SKIP_LAST) begin
                        state <= COUNT;
                    end else begin
                        state <= SKIP;
                    end
                end else if (in_bit && ((cur_run + 4'd1) == RUN_TGT)) begin
                    // The stuffed 0 becomes the packet end, so the data 1 is not last.
                    run       <= cur_run + 4'd1;
                    pend_last <= in_last;
                    out_last  <= 1'b0;
                    state     <= STUFF;
                end else begin
                    run   <= in_bit ? (cur_run + 4'd1) : 4'd0;
                    state <= in_last ? IDLE : COUNT;
                end
            end else if (state == STUFF && slot_free) begin
                out_valid <= 1'b1;
                out_bit   <= 1'b0;
                out_last  <= pend_last;
                run       <= 4'd0;
                if (stuff_cnt != '1) begin
                    stuff_cnt <= stuff_cnt + CNT_W'(1);
                end
                state <= pend_last ? IDLE : COUNT;
            end
        end
    end

endmodule
